wb_arbiter: RTL and testbench

Write-back arbiter for the CPU core: the single producer of the register file's write port (destination index, write data, write enable). Merges results from the single-cycle ALU path and the multi-cycle memory path, queues results that collide, drops writes to x0 and keeps a per-register busy scoreboard so decode can stall on pending destinations. Sits between execute/memory stages and the register file.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_queue.sv | 58 +++++
 rtl/wb_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Write-back arbiter shared types.
// Register-file write entry and core widths.
package wb_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 2 ** REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Write-back collision queue.
// Circular buffer, two pushes and one pop per cycle.
module wb_queue
  import wb_pkg::*;
#(
  parameter  int QDEPTH = 4,
  localparam int CW     = $clog2(QDEPTH + 1),
  localparam int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push0_en,
  input  wb_entry_t     push0,
  input  logic          push1_en,
  input  wb_entry_t     push1,
  input  logic          pop,
  output wb_entry_t     head,
  output logic [CW-1:0] count
);

  wb_entry_t       mem [QDEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_nxt1;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(QDEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign wr_nxt1 = inc(wr_ptr);
  assign head    = mem[rd_ptr];

  // Entry storage; push1 lands behind push0.
  always_ff @(posedge clk) begin
    if (push0_en) mem[wr_ptr]  <= push0;
    if (push1_en) mem[wr_nxt1] <= push1;
  end

  // Pointers and occupancy, flushed by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push1_en)      wr_ptr <= inc(wr_nxt1);
      else if (push0_en) wr_ptr <= wr_nxt1;
      if (pop)           rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push0_en)
                     + CW'(push1_en)
                     - CW'(pop);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU/memory merge,
// collision queue, x0 drop, busy scoreboard.
module wb_arbiter #(
  parameter  int DATA_W   = wb_pkg::DATA_W,
  parameter  int REG_AW   = wb_pkg::REG_AW,
  parameter  int QDEPTH   = 4,
  localparam int NUM_REGS = 2 ** REG_AW,
  localparam int CW       = $clog2(QDEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  input  logic [REG_AW-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [REG_AW-1:0]   mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                alloc_en,
  input  logic [REG_AW-1:0]   alloc_rd,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_wd,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] busy,
  output logic [CW-1:0]       q_count
);

  import wb_pkg::*;

  wb_entry_t alu_e;
  wb_entry_t mem_e;
  wb_entry_t head;
  wb_entry_t sel;
  wb_entry_t push0;

  logic alu_take;
  logic mem_take;
  logic sel_q;
  logic sel_a;
  logic sel_m;
  logic sel_v;
  logic pop;
  logic alu_enq;
  logic mem_enq;
  logic push0_en;
  logic push1_en;

  logic [NUM_REGS-1:0] busy_n;

  assign alu_e = '{rd: alu_rd, data: alu_data};
  assign mem_e = '{rd: mem_rd, data: mem_data};

  assign mem_ready = q_count <= CW'(QDEPTH - 2);

  assign alu_take = alu_valid && (alu_rd != '0);
  assign mem_take = mem_valid && mem_ready
                 && (mem_rd != '0);

  assign sel_q = q_count != '0;
  assign sel_a = !sel_q && alu_take;
  assign sel_m = !sel_q && !alu_take && mem_take;

  // Oldest first: queue head, then ALU, then memory.
  always_comb begin
    sel     = '0;
    sel_v   = 1'b0;
    pop     = 1'b0;
    alu_enq = 1'b0;
    mem_enq = 1'b0;
    unique case (1'b1)
      sel_q: begin
        sel     = head;
        sel_v   = 1'b1;
        pop     = 1'b1;
        alu_enq = alu_take;
        mem_enq = mem_take;
      end
      sel_a: begin
        sel     = alu_e;
        sel_v   = 1'b1;
        mem_enq = mem_take;
      end
      sel_m: begin
        sel   = mem_e;
        sel_v = 1'b1;
      end
      default: ;
    endcase
  end

  assign push0_en = alu_enq | mem_enq;
  assign push0    = alu_enq ? alu_e : mem_e;
  assign push1_en = alu_enq & mem_enq;

  wb_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push0_en (push0_en),
    .push0    (push0),
    .push1_en (push1_en),
    .push1    (mem_e),
    .pop      (pop),
    .head     (head),
    .count    (q_count)
  );

  // Register-file write port; index/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_wd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= sel_v;
      if (sel_v) begin
        rf_wd    <= sel.rd;
        rf_wdata <= sel.data;
      end
    end
  end

  // Clear on the writing edge, then set; set wins.
  always_comb begin
    busy_n = busy;
    if (rf_we) busy_n[rf_wd] = 1'b0;
    if (alloc_en && (alloc_rd != '0))
      busy_n[alloc_rd] = 1'b1;
    busy_n[0] = 1'b0;
  end

  // Pending-destination scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_n;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter.
// Expected values hand-computed or from an order model.
module tb_wb_arbiter;

  localparam int QD = 4;
  localparam int CW = $clog2(QD + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        alloc_en;
  logic [4:0]  alloc_rd;
  logic        rf_we;
  logic [4:0]  rf_wd;
  logic [31:0] rf_wdata;
  logic [31:0] busy;
  logic [CW-1:0] q_count;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  wb_arbiter #(
    .DATA_W (32),
    .REG_AW (5),
    .QDEPTH (QD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .alloc_en  (alloc_en),
    .alloc_rd  (alloc_rd),
    .rf_we     (rf_we),
    .rf_wd     (rf_wd),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .q_count   (q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    alloc_en  = 1'b0;
  endtask

  int  exp_q[$];
  int  m;
  int  e;
  bit  pend;
  bit  fire;
  bit  saw_full;

  initial begin
    idle();
    alu_rd = '0; alu_data = '0;
    mem_rd = '0; mem_data = '0;
    alloc_rd = '0;

    // reset state
    #12;
    chk("rst_we",    64'(rf_we),     64'd0);
    chk("rst_wd",    64'(rf_wd),     64'd0);
    chk("rst_wdata", 64'(rf_wdata),  64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_qc",    64'(q_count),   64'd0);
    chk("rst_mrdy",  64'(mem_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // alloc x5 at N-2, ALU write at N
    alloc_en = 1'b1; alloc_rd = 5'd5;
    tick();
    chk("alloc5_busy", 64'(busy), 64'h20);
    alloc_en = 1'b0;
    tick();
    alu_valid = 1'b1; alu_rd = 5'd5;
    alu_data = 32'h32;
    tick();
    alu_valid = 1'b0;
    chk("alu5_we",    64'(rf_we),    64'd1);
    chk("alu5_wd",    64'(rf_wd),    64'd5);
    chk("alu5_wdata", 64'(rf_wdata), 64'h32);
    chk("alu5_busy_n1", 64'(busy[5]), 64'd1);
    tick();
    chk("alu5_busy_n2", 64'(busy), 64'd0);
    chk("alu5_we_off",  64'(rf_we), 64'd0);
    chk("alu5_wd_hold", 64'(rf_wd), 64'd5);

    // collision ALU r3 / mem r4
    alu_valid = 1'b1; alu_rd = 5'd3;
    alu_data = 32'hA;
    mem_valid = 1'b1; mem_rd = 5'd4;
    mem_data = 32'hB;
    chk("col_mrdy", 64'(mem_ready), 64'd1);
    tick();
    idle();
    chk("col_wd1",    64'(rf_wd),    64'd3);
    chk("col_wdata1", 64'(rf_wdata), 64'hA);
    chk("col_we1",    64'(rf_we),    64'd1);
    chk("col_qc1",    64'(q_count),  64'd1);
    tick();
    chk("col_we2",    64'(rf_we),    64'd1);
    chk("col_wd2",    64'(rf_wd),    64'd4);
    chk("col_wdata2", 64'(rf_wdata), 64'hB);
    chk("col_qc2",    64'(q_count),  64'd0);
    tick();
    chk("col_we3", 64'(rf_we), 64'd0);

    // writes to x0 are discarded
    alu_valid = 1'b1; alu_rd = 5'd0;
    alu_data = 32'h55;
    mem_valid = 1'b1; mem_rd = 5'd0;
    mem_data = 32'h66;
    chk("x0_mrdy", 64'(mem_ready), 64'd1);
    tick();
    idle();
    chk("x0_we", 64'(rf_we),   64'd0);
    chk("x0_qc", 64'(q_count), 64'd0);
    tick();
    chk("x0_we2", 64'(rf_we), 64'd0);

    // alloc x7 on the edge that clears x7
    alloc_en = 1'b1; alloc_rd = 5'd7;
    tick();
    chk("a7_busy", 64'(busy[7]), 64'd1);
    alloc_en = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7;
    alu_data = 32'h77;
    tick();
    alu_valid = 1'b0;
    chk("a7_we", 64'(rf_we), 64'd1);
    chk("a7_wd", 64'(rf_wd), 64'd7);
    alloc_en = 1'b1; alloc_rd = 5'd7;
    tick();
    alloc_en = 1'b0;
    chk("a7_setwins", 64'(busy[7]), 64'd1);
    tick();
    chk("a7_hold", 64'(busy[7]), 64'd1);

    // ALU + memory every cycle for 12 cycles
    m = 0;
    saw_full = 1'b0;
    for (int i = 0; i < 12; i++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'(1 + i);
      alu_data  = 32'(i);
      mem_valid = 1'b1;
      mem_rd    = 5'(16 + m);
      mem_data  = 32'(100 + m);
      chk("st_mrdy", 64'(mem_ready),
          64'(q_count <= CW'(QD - 2)));
      chk("st_alu_room", 64'(q_count < CW'(QD)),
          64'd1);
      if (q_count == CW'(QD - 1)) saw_full = 1'b1;
      fire = mem_ready;
      exp_q.push_back(1 + i);
      if (fire) exp_q.push_back(16 + m);
      pend = exp_q.size() > 0;
      tick();
      if (fire) m++;
      chk("st_we", 64'(rf_we), 64'(pend));
      if (pend) begin
        e = exp_q.pop_front();
        chk("st_wd", 64'(rf_wd), 64'(e));
      end
      chk("st_qmax", 64'(q_count <= CW'(QD - 1)),
          64'd1);
    end
    idle();
    chk("st_saw_full", 64'(saw_full), 64'd1);
    for (int k = 0; k < 8; k++) begin
      if (exp_q.size() == 0) break;
      tick();
      e = exp_q.pop_front();
      chk("dr_we", 64'(rf_we), 64'd1);
      chk("dr_wd", 64'(rf_wd), 64'(e));
    end
    chk("dr_empty", 64'(exp_q.size()), 64'd0);
    chk("dr_qc",    64'(q_count),      64'd0);
    tick();
    chk("dr_we_off", 64'(rf_we), 64'd0);

    // reset mid-stream: two queued, busy[9]
    alloc_en = 1'b1; alloc_rd = 5'd9;
    tick();
    alloc_en = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd10;
    mem_valid = 1'b1; mem_rd = 5'd11;
    tick();
    alu_rd = 5'd12;
    mem_rd = 5'd13;
    tick();
    idle();
    chk("mr_qc_pre",   64'(q_count), 64'd2);
    chk("mr_busy_pre", 64'(busy[9]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_we",   64'(rf_we),     64'd0);
    chk("mr_qc",   64'(q_count),   64'd0);
    chk("mr_busy", 64'(busy),      64'd0);
    chk("mr_mrdy", 64'(mem_ready), 64'd1);
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    chk("mr_post_we1", 64'(rf_we),   64'd0);
    chk("mr_post_qc",  64'(q_count), 64'd0);
    tick();
    chk("mr_post_we2", 64'(rf_we), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
